// File: rtl/residual_checker.sv
// Residual checker: re-streams N stored samples against latched b0/b1, emitting
// err = y - (b0 + b1*x) per sample plus an outlier count. Define SATURATE_EN to clamp instead of wrap.
module residual_checker #(
  parameter int W      = 20,
  parameter int FRAC   = 10,
  parameter int N      = 150,
  parameter int THRESH = 512
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         coeff_done,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] b1,
  input  logic [W-1:0] x_bus,
  input  logic [W-1:0] y_bus,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [7:0]   idx,
  output logic         err_valid,
  output logic [W-1:0] err_out,
  output logic         outlier,
  output logic [7:0]   outlier_cnt,
  output logic         check_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state;
  logic signed [W-1:0] b0_r, b1_r, x0;
  logic [W-1:0]        y0, y1, s1;
  logic                v0, v1;
  logic                accept;
  logic signed [2*W-1:0] prod;
  logic [W-1:0]        s_red, yhat, err_red;
  logic [W:0]          yhat_w, err_w, mag;
  logic                out_flag;

  assign accept = in_valid & in_ready;
  assign prod   = (2*W)'(b1_r) * (2*W)'(x0);
  assign yhat_w = {b0_r[W-1], b0_r} + {s1[W-1], s1};
  assign err_w  = {y1[W-1], y1} - {yhat[W-1], yhat};

`ifdef SATURATE_EN
  localparam logic [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};

  function automatic logic [W-1:0] clamp1(input logic [W:0] v);
    if (v[W] == v[W-1]) return v[W-1:0];
    return v[W] ? S_MIN : S_MAX;
  endfunction

  // Product fits after the shift only if every bit above the result's sign matches it
  always_comb begin
    if (prod[2*W-1:FRAC+W-1] == {(W-FRAC+1){prod[2*W-1]}})
      s_red = prod[FRAC +: W];
    else
      s_red = prod[2*W-1] ? S_MIN : S_MAX;
    yhat    = clamp1(yhat_w);
    err_red = clamp1(err_w);
  end

  logic unused_frac;
  assign unused_frac = ^prod[FRAC-1:0];
`else
  always_comb begin
    s_red   = prod[FRAC +: W];
    yhat    = yhat_w[W-1:0];
    err_red = err_w[W-1:0];
  end

  logic unused_bits;
  assign unused_bits = ^{prod[2*W-1:FRAC+W], prod[FRAC-1:0], yhat_w[W], err_w[W]};
`endif

  // Magnitude at W+1 bits so the most-negative residual maps to 2^(W-1)
  assign mag      = err_red[W-1] ? ({1'b0, ~err_red} + (W+1)'(1)) : {1'b0, err_red};
  assign out_flag = mag > (W+1)'(THRESH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      b0_r        <= '0;
      b1_r        <= '0;
      x0          <= '0;
      y0          <= '0;
      y1          <= '0;
      s1          <= '0;
      v0          <= 1'b0;
      v1          <= 1'b0;
      idx         <= '0;
      in_ready    <= 1'b0;
      err_valid   <= 1'b0;
      err_out     <= '0;
      outlier     <= 1'b0;
      outlier_cnt <= '0;
      check_done  <= 1'b0;
    end else begin
      check_done <= 1'b0;

      v0 <= accept;
      if (accept) begin
        x0 <= x_bus;
        y0 <= y_bus;
      end

      v1 <= v0;
      if (v0) begin
        s1 <= s_red;
        y1 <= y0;
      end

      err_valid <= v1;
      if (v1) begin
        err_out <= err_red;
        outlier <= out_flag;
        if (out_flag && outlier_cnt != 8'hFF) outlier_cnt <= outlier_cnt + 8'd1;
      end

      case (state)
        IDLE: begin
          // A coeff_done coinciding with check_done belongs to the finished pass
          if (coeff_done && !check_done) begin
            b0_r        <= b0;
            b1_r        <= b1;
            idx         <= '0;
            outlier_cnt <= '0;
            in_ready    <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (idx == 8'(N-1)) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end else begin
              idx <= idx + 8'd1;
            end
          end
        end
        DRAIN: begin
          if (err_valid && !v0 && !v1) begin
            check_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_residual_checker.sv
// Self-checking bench for residual_checker: directed passes plus $urandom samples
// checked cycle-by-cycle against an arithmetic reference model.
module tb_residual_checker;

  localparam int N = 150;

  logic        clk, rst, coeff_done, in_valid;
  logic [19:0] b0, b1, x_bus, y_bus;
  logic        in_ready, err_valid, outlier, check_done;
  logic [7:0]  idx, outlier_cnt;
  logic [19:0] err_out;

  residual_checker #(.W(20), .FRAC(10), .N(N), .THRESH(512)) dut (
    .clk(clk), .rst(rst), .coeff_done(coeff_done), .b0(b0), .b1(b1),
    .x_bus(x_bus), .y_bus(y_bus), .in_valid(in_valid), .in_ready(in_ready),
    .idx(idx), .err_valid(err_valid), .err_out(err_out), .outlier(outlier),
    .outlier_cnt(outlier_cnt), .check_done(check_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [19:0] e;
    logic        o;
  } exp_t;

  exp_t        q[$];
  int          errors, checks;
  int          cyc, midx, mcnt, mstate, done_at, done_seen, pass_acc;
  bit          mdone_now;
  longint      mb0, mb1;
  logic [19:0] last_e;
  logic        last_o;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint red(input longint v);
    longint m;
`ifdef SATURATE_EN
    m = v;
    if (m > 524287) m = 524287;
    if (m < -524288) m = -524288;
`else
    m = ((v % 1048576) + 1048576) % 1048576;
    if (m >= 524288) m = m - 1048576;
`endif
    return m;
  endfunction

  function automatic longint floor_div(input longint p, input longint d);
    if (p >= 0) return p / d;
    return -((-p + d - 1) / d);
  endfunction

  function automatic longint sx(input logic [19:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint model_yhat(input longint x);
    return red(mb0 + red(floor_div(mb1 * x, 1024)));
  endfunction

  function automatic logic [19:0] rnd_x();
    return 20'(longint'($urandom_range(0, 200000)) - 100000);
  endfunction

  function automatic logic [19:0] near_y(input logic [19:0] xv);
    return 20'(model_yhat(sx(xv)) + longint'($urandom_range(0, 2000)) - 1000);
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, then check outputs
  task automatic tick(input logic iv, input logic [19:0] xv, input logic [19:0] yv,
                      input logic cd, input logic [19:0] b0v, input logic [19:0] b1v);
    longint e;
    exp_t   t;
    in_valid = iv; x_bus = xv; y_bus = yv; coeff_done = cd; b0 = b0v; b1 = b1v;
    chk("in_ready", 40'(in_ready), 40'(mstate == 1));
    chk("idx", 40'(idx), 40'(midx));
    if (iv && mstate == 1) begin
      e = red(sx(yv) - model_yhat(sx(xv)));
      t.due = cyc + 3;
      t.e   = 20'(e);
      t.o   = (e > 512) || (e < -512);
      q.push_back(t);
      pass_acc++;
      if (midx == N - 1) mstate = 2;
      else midx++;
    end
    if (mstate == 0 && cd && !mdone_now) begin
      mb0 = sx(b0v); mb1 = sx(b1v); midx = 0; mcnt = 0; mstate = 1;
    end
    @(posedge clk); #1; cyc++;
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("err_valid", 40'(err_valid), 40'(1));
      last_e = q[0].e;
      last_o = q[0].o;
      if (last_o && mcnt < 255) mcnt++;
      void'(q.pop_front());
      if (mstate == 2 && q.size() == 0) done_at = cyc + 1;
    end else begin
      chk("err_valid", 40'(err_valid), 40'(0));
    end
    chk("err_out", 40'(err_out), 40'(last_e));
    chk("outlier", 40'(outlier), 40'(last_o));
    chk("outlier_cnt", 40'(outlier_cnt), 40'(mcnt));
    mdone_now = (cyc == done_at);
    chk("check_done", 40'(check_done), 40'(mdone_now));
    if (check_done === 1'b1) done_seen++;
    if (mdone_now) mstate = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b0; in_valid = 1'b0; coeff_done = 1'b0;
    #1;
    chk("rst_in_ready", 40'(in_ready), 40'(0));
    chk("rst_idx", 40'(idx), 40'(0));
    chk("rst_err_valid", 40'(err_valid), 40'(0));
    chk("rst_err_out", 40'(err_out), 40'(0));
    chk("rst_outlier", 40'(outlier), 40'(0));
    chk("rst_outlier_cnt", 40'(outlier_cnt), 40'(0));
    chk("rst_check_done", 40'(check_done), 40'(0));
    q.delete();
    mstate = 0; midx = 0; mcnt = 0; last_e = '0; last_o = 1'b0;
    done_at = -1; mdone_now = 1'b0;
    repeat (2) begin @(posedge clk); #1; cyc++; end
    rst = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 12 && mstate != 0; k++)
      tick(1'b0, '0, '0, mdone_now, 20'h12345, 20'h00001);
    tick(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; done_seen = 0; pass_acc = 0;
    in_valid = 1'b0; coeff_done = 1'b0; b0 = '0; b1 = '0; x_bus = '0; y_bus = '0;
    apply_reset();

    // Pass A: exact fit, outlier, strict boundary, bubbles, ignored mid-run coeff_done
    done_seen = 0;
    tick(1'b0, '0, '0, 1'b1, 20'd2048, 20'd512);
    tick(1'b1, 20'd4096, 20'd4096, 1'b0, '0, '0);
    tick(1'b1, 20'd4096, 20'd4696, 1'b0, '0, '0);
    tick(1'b1, 20'd4096, 20'd4608, 1'b0, '0, '0);
    chk("fit_err", 40'(err_out), 40'(0));
    chk("fit_outlier", 40'(outlier), 40'(0));
    tick(1'b0, '0, '0, 1'b0, '0, '0);
    chk("out600_err", 40'(err_out), 40'(600));
    chk("out600_flag", 40'(outlier), 40'(1));
    chk("out600_cnt", 40'(outlier_cnt), 40'(1));
    tick(1'b1, 20'd4096, 20'd4000, 1'b0, '0, '0);
    chk("thr512_err", 40'(err_out), 40'(512));
    chk("thr512_flag", 40'(outlier), 40'(0));
    tick(1'b0, '0, '0, 1'b0, '0, '0);
    tick(1'b1, 20'd8192, 20'd6144, 1'b1, 20'd99999, 20'd1);
    for (int k = 0; k < 2000 && mstate == 1; k++) begin
      logic [19:0] xv;
      xv = rnd_x();
      tick(1'($urandom_range(0, 3) != 0), xv, near_y(xv), 1'($urandom_range(0, 9) == 0),
           20'($urandom), 20'($urandom));
    end
    drain();
    chk("passA_done_pulses", 40'(done_seen), 40'(1));

    // Pass B: continuous stream, alternating exact fit / +600 outlier
    done_seen = 0;
    tick(1'b0, '0, '0, 1'b1, 20'd2048, 20'd512);
    for (int k = 0; k < N; k++) begin
      logic [19:0] xv;
      xv = rnd_x();
      tick(1'b1, xv, 20'(model_yhat(sx(xv)) + ((k % 2 == 1) ? 600 : 0)), 1'b0, '0, '0);
    end
    chk("passB_in_ready_low", 40'(in_ready), 40'(0));
    drain();
    chk("passB_done_pulses", 40'(done_seen), 40'(1));
    chk("passB_outlier_cnt", 40'(outlier_cnt), 40'(75));
    chk("passB_idx_end", 40'(idx), 40'(N - 1));

    // Pass C: product overflow, then reset after 20 accepts
    done_seen = 0;
    tick(1'b0, '0, '0, 1'b1, 20'd0, 20'h7FFFF);
    pass_acc = 0;
    tick(1'b1, 20'h7FFFF, 20'd0, 1'b0, '0, '0);
    tick(1'b0, '0, '0, 1'b0, '0, '0);
    tick(1'b0, '0, '0, 1'b0, '0, '0);
`ifdef SATURATE_EN
    chk("ovf_err", 40'(err_out), 40'(20'h80001));
`else
    chk("ovf_err", 40'(err_out), 40'(20'h00400));
`endif
    chk("ovf_outlier", 40'(outlier), 40'(1));
    for (int k = 0; k < 200 && pass_acc < 20; k++)
      tick(1'($urandom_range(0, 1)), 20'($urandom), 20'($urandom), 1'b0, '0, '0);
    apply_reset();
    repeat (4) tick(1'b1, 20'($urandom), 20'($urandom), 1'b0, '0, '0);
    chk("passC_no_done", 40'(done_seen), 40'(0));

    // Pass D: clean restart with full-range random coefficients and samples
    done_seen = 0;
    tick(1'b0, '0, '0, 1'b1, 20'($urandom), 20'($urandom));
    for (int k = 0; k < 2000 && mstate == 1; k++)
      tick(1'($urandom_range(0, 4) != 0), 20'($urandom), 20'($urandom), 1'b0, '0, '0);
    drain();
    chk("passD_done_pulses", 40'(done_seen), 40'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
